// File: rtl/audiodac_sdm_if.sv
// FIFO read-side handshake between the audio FIFO (master) and the delta-sigma DAC (slave).
interface audiodac_sdm_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] fifo_outdata;
  logic             fifo_empty;
  logic             fifo_outdata_rd;

  modport master (output fifo_outdata, fifo_empty, input fifo_outdata_rd);
  modport slave  (input fifo_outdata, fifo_empty, output fifo_outdata_rd);
endinterface

// File: rtl/audiodac_sdm.sv
// 1st/2nd-order error-feedback delta-sigma DAC modulator fed from the audio FIFO.
// Define AUDIODAC_SDM_INTERP_EN for linear interpolation between samples (default: zero-order hold).
module audiodac_sdm #(
  parameter int WIDTH        = 16,
  parameter int OSR_LOG2_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 mode_i,
  input  logic [1:0]           osr_i,
  input  logic [3:0]           volume_i,
  audiodac_sdm_if.slave        fifo,
  output logic                 ds_o,
  output logic                 ds_n_o,
  output logic                 underrun_o
);
  localparam int IW = WIDTH + 3;
  localparam int VW = WIDTH + 5;
  localparam int CW = OSR_LOG2_MAX;
  localparam logic signed [IW-1:0] FS   = IW'(2**(WIDTH-1));
  localparam logic signed [VW-1:0] VMAX = VW'(4*(2**(WIDTH-1)) - 1);

  logic [CW-1:0]          cnt_q, cnt_d, cnt_last;
  logic [1:0]             osr_q, osr_d;
  logic signed [WIDTH-1:0] sample_q, sample_d, new_s, base;
  logic signed [IW-1:0]   e1_q, e1_d, e2_q, e2_d, xb, x, v, q, e;
  logic signed [VW-1:0]   xe, e1e, e2e, vf, vs;
  logic                   ds_q, ds_d, dsn_q, dsn_d, und_q, und_d;
  logic                   fetch, rd, vpos;
  logic [3:0]             lq;

  assign lq       = 4'd5 + {2'b00, osr_q};
  assign cnt_last = CW'((32'd1 << lq) - 32'd1);
  assign fetch    = enable_i & (cnt_q == '0);
  // Gated by rst_i so the FIFO never sees a read on a cycle that is being reset away.
  assign rd       = fetch & ~fifo.fifo_empty & ~rst_i;
  assign fifo.fifo_outdata_rd = rd;
  assign new_s    = {~fifo.fifo_outdata[WIDTH-1], fifo.fifo_outdata[WIDTH-2:0]};

`ifdef AUDIODAC_SDM_INTERP_EN
  localparam int AW = WIDTH + OSR_LOG2_MAX;
  logic signed [AW-1:0]  acc_q, acc_d, acc_sh, sample_ext;
  logic signed [WIDTH:0] diff_q, diff_d;
  logic [3:0]            ln;
  logic                  unused_acc_hi;

  assign ln            = 4'd5 + {2'b00, osr_i};
  assign sample_ext    = {{(AW-WIDTH){sample_q[WIDTH-1]}}, sample_q};
  assign acc_sh        = acc_q >>> lq;
  assign base          = acc_sh[WIDTH-1:0];
  assign unused_acc_hi = ^acc_sh[AW-1:WIDTH];

  // acc reloads with the outgoing sample at every fetch, so rounding never accumulates.
  always_comb begin
    acc_d  = acc_q;
    diff_d = diff_q;
    if (!enable_i) begin
      acc_d  = '0;
      diff_d = '0;
    end else if (fetch) begin
      if (!fifo.fifo_empty) begin
        acc_d  = sample_ext <<< ln;
        diff_d = {new_s[WIDTH-1], new_s} - {sample_q[WIDTH-1], sample_q};
      end else begin
        acc_d  = sample_ext <<< lq;
        diff_d = '0;
      end
    end else begin
      acc_d = acc_q + {{(AW-WIDTH-1){diff_q[WIDTH]}}, diff_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      diff_q <= '0;
    end else begin
      acc_q  <= acc_d;
      diff_q <= diff_d;
    end
  end
`else
  assign base = sample_q;
`endif

  assign xb  = {{3{base[WIDTH-1]}}, base};
  assign x   = xb >>> volume_i;
  assign xe  = {{2{x[IW-1]}}, x};
  assign e1e = {{2{e1_q[IW-1]}}, e1_q};
  assign e2e = {{2{e2_q[IW-1]}}, e2_q};
  assign vf  = mode_i ? (xe - (e1e <<< 1) + e2e) : (xe - e1e);
  assign vs  = (vf > VMAX) ? VMAX : ((vf < -VMAX) ? -VMAX : vf);
  assign v   = vs[IW-1:0];
  assign vpos = ~v[IW-1];
  assign q   = vpos ? FS : -FS;
  assign e   = q - v;

  always_comb begin
    cnt_d    = cnt_q;
    osr_d    = osr_q;
    sample_d = sample_q;
    e1_d     = e1_q;
    e2_d     = e2_q;
    ds_d     = ds_q;
    dsn_d    = dsn_q;
    und_d    = und_q;
    if (fetch && fifo.fifo_empty) und_d = 1'b1;
    if (!enable_i) begin
      cnt_d    = '0;
      osr_d    = osr_i;
      sample_d = '0;
      e1_d     = '0;
      e2_d     = '0;
      ds_d     = 1'b0;
      dsn_d    = 1'b0;
    end else begin
      cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + CW'(1);
      if (rd) begin
        sample_d = new_s;
        osr_d    = osr_i;
      end
      e2_d  = e1_q;
      e1_d  = e;
      ds_d  = vpos;
      dsn_d = ~vpos;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      osr_q    <= osr_i;
      sample_q <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      ds_q     <= 1'b0;
      dsn_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      osr_q    <= osr_d;
      sample_q <= sample_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      ds_q     <= ds_d;
      dsn_q    <= dsn_d;
      und_q    <= und_d;
    end
  end

  assign ds_o       = ds_q;
  assign ds_n_o     = dsn_q;
  assign underrun_o = und_q;
endmodule

// File: tb/tb_audiodac_sdm.sv
// Scoreboard bench for audiodac_sdm: expected read-pulse cycles are queued by stimulus and
// popped by a negedge monitor; densities and internal x are checked against hand-derived values.
module tb_audiodac_sdm;
  localparam int W = 16;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0;
  logic [1:0] osr = 2'd0;
  logic [3:0] vol = 4'd0;
  logic       ds, dsn, und;

  audiodac_sdm_if #(.WIDTH(W)) fif ();

  audiodac_sdm #(.WIDTH(W), .OSR_LOG2_MAX(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mode_i(mode), .osr_i(osr),
    .volume_i(vol), .fifo(fif), .ds_o(ds), .ds_n_o(dsn), .underrun_o(und)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0, n_err = 0;
  int   exp_q[$];
  logic prev_rd = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    n_chk++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  // Scoreboard monitor: every read pulse must match the next queued cycle and be 1 clk wide.
  always @(negedge clk) begin
    if (fif.fifo_outdata_rd) begin
      if (exp_q.size() == 0) chk("rd_unexpected_cyc", cyc, -1);
      else                   chk("rd_cycle", cyc, exp_q.pop_front());
      chk("rd_width", int'(prev_rd), 0);
    end
    prev_rd = fif.fifo_outdata_rd;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_en(input int p, input int n, output int ones, output logic [7:0] first);
    int c, ncompl;
    ones = 0; first = '0; ncompl = 0;
    c = cyc;
    en = 1'b1;
    for (int j = 0; j * p < n; j++) exp_q.push_back(c + j * p);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      ones += int'(ds);
      if (j >= 1 && j <= 8) first[j-1] = ds;
      if (j > 0 && ds == dsn) ncompl++;
      step();
    end
    en = 1'b0;
    chk("rd_missing", exp_q.size(), 0);
    chk("dsn_compl", ncompl, 0);
  endtask

  int         ones, c, xv;
  logic [7:0] first;

  initial begin
    fif.fifo_outdata = 16'h8000;
    fif.fifo_empty   = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ds", int'(ds), 0);
    chk("rst_dsn", int'(dsn), 0);
    chk("rst_und", int'(und), 0);
    chk("rst_rd", int'(fif.fifo_outdata_rd), 0);
    step(); rst = 1'b0; step();

    // midscale, 2nd order: period-4 pattern 1,0,0,1
    mode = 1'b1; osr = 2'd0; vol = 4'd0;
    run_en(32, 256, ones, first);
    chk_rng("t1_density", ones, 127, 129);
    chk("t1_first", int'(first), 8'b10011001);
    step();

    // osr change mid-period takes effect only at the following fetch
    c = cyc; en = 1'b1;
    exp_q.push_back(c); exp_q.push_back(c + 32);
    exp_q.push_back(c + 288); exp_q.push_back(c + 544);
    repeat (10) step();
    osr = 2'd3;
    repeat (535) step();
    en = 1'b0;
    chk("t4_rd_missing", exp_q.size(), 0);
    osr = 2'd0;
    step();

    // 0xC000 first order: 75%, and 62.5% at vol 1
    mode = 1'b0; fif.fifo_outdata = 16'hC000;
    run_en(32, 4096, ones, first);
    chk_rng("t2_density", ones, 3031, 3113);
`ifndef AUDIODAC_SDM_INTERP_EN
    chk("t2_first", int'(first), 8'b11011101);
`endif
    step();
    vol = 4'd1;
    run_en(32, 4096, ones, first);
    chk_rng("t2_density_vol1", ones, 2519, 2601);
    vol = 4'd0;
    step();

    // underrun on empty fetch, sticky through enable toggle
    c = cyc; en = 1'b1; exp_q.push_back(c);
    step();
    fif.fifo_empty = 1'b1;
    repeat (31) step();
    @(negedge clk);
    chk("t3_rd_on_empty", int'(fif.fifo_outdata_rd), 0);
    chk("t3_und_before", int'(und), 0);
    step();
    @(negedge clk);
    chk("t3_und_set", int'(und), 1);
    xv = int'($signed(dut.x));
    chk("t3_x_held", xv, 16'h4000);
    step(); en = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("t3_und_disabled", int'(und), 1);
    en = 1'b1;
    step();
    @(negedge clk);
    chk("t3_und_reenabled", int'(und), 1);
    en = 1'b0; fif.fifo_empty = 1'b0;
    step();

    // reset landing on a fetch cycle
    mode = 1'b1; fif.fifo_outdata = 16'hFFFF;
    c = cyc; en = 1'b1;
    exp_q.push_back(c); exp_q.push_back(c + 32);
    repeat (64) step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rd_in_rst", int'(fif.fifo_outdata_rd), 0);
    chk("t6_und_pre", int'(und), 1);
    step();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("t6_ds", int'(ds), 0);
    chk("t6_dsn", int'(dsn), 0);
    chk("t6_und", int'(und), 0);
    chk("t6_rd", int'(fif.fifo_outdata_rd), 0);
    chk("t6_rd_missing", exp_q.size(), 0);
    step();

    // full scale 2nd order: saturation keeps density near 100%
    run_en(32, 1024, ones, first);
    chk_rng("t6_density", ones, 1000, 1024);
`ifndef AUDIODAC_SDM_INTERP_EN
    chk("t6_first", int'(first), 8'b11111101);
`endif
    step();

    // 0x8000 then 0x8020: ramp with interpolation, single step otherwise
    mode = 1'b0; osr = 2'd0; vol = 4'd0; fif.fifo_outdata = 16'h8000;
    c = cyc; en = 1'b1;
    exp_q.push_back(c); exp_q.push_back(c + 32); exp_q.push_back(c + 64);
    step();
    fif.fifo_outdata = 16'h8020;
    repeat (31) step();
    @(negedge clk);
    xv = int'($signed(dut.x));
    chk("t5_x_fetch", xv, 0);
    step();
    for (int j = 0; j <= 32; j++) begin
      @(negedge clk);
      xv = int'($signed(dut.x));
`ifdef AUDIODAC_SDM_INTERP_EN
      chk("t5_x_ramp", xv, j);
`else
      chk("t5_x_hold", xv, 32);
`endif
      step();
    end
    en = 1'b0;
    chk("t5_rd_missing", exp_q.size(), 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
